// File: rtl/ddr3_axi_wr_packer.sv
// AXI4 write burst to 128-bit DDR3 store packer.
// Optional macro AXI_WR_BURST_CHECK_EN enables burst/len/wlast checks and SLVERR.
module ddr3_axi_wr_packer #(
    parameter int WIDTH = 32,
    parameter int ADDRS = 27,
    parameter int IDS   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             axi_awvalid_i,
    output logic             axi_awready_o,
    input  logic [ADDRS-1:0] axi_awaddr_i,
    input  logic [IDS-1:0]   axi_awid_i,
    input  logic [7:0]       axi_awlen_i,
    input  logic [1:0]       axi_awburst_i,
    input  logic             axi_wvalid_i,
    output logic             axi_wready_o,
    input  logic             axi_wlast_i,
    input  logic [WIDTH/8-1:0] axi_wstrb_i,
    input  logic [WIDTH-1:0] axi_wdata_i,
    output logic             axi_bvalid_o,
    input  logic             axi_bready_i,
    output logic [1:0]       axi_bresp_o,
    output logic [IDS-1:0]   axi_bid_o,
    output logic             mem_store_o,
    input  logic             mem_accept_i,
    output logic [ADDRS-1:0] mem_addr_o,
    output logic [IDS-1:0]   mem_reqid_o,
    output logic [15:0]      mem_mask_o,
    output logic [127:0]     mem_data_o
);

    localparam int BEATS = 128 / WIDTH;
    localparam int SW    = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STORE,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [8:0]       count_q;
    logic [7:0]       len_q;
    logic [1:0]       burst_q;
    logic [IDS-1:0]   id_q;
    logic [ADDRS-1:0] addr_q;
    logic [15:0]      mask_q;
    logic [127:0]     data_q;
    logic             aw_fire;
    logic             w_fire;
    logic             last_beat;
    logic             beat_err;

    assign axi_awready_o = (state_q == IDLE) && !reset;
    assign axi_wready_o  = (state_q == DATA) && !reset;
    assign axi_bvalid_o  = (state_q == RESP) && !reset;
    assign mem_store_o   = (state_q == STORE) && !reset;

    assign aw_fire = axi_awvalid_i && axi_awready_o;
    assign w_fire  = axi_wvalid_i && axi_wready_o;

    assign axi_bid_o   = id_q;
    assign mem_reqid_o = id_q;
    assign mem_addr_o  = addr_q;
    assign mem_mask_o  = mask_q;
    assign mem_data_o  = data_q;

`ifdef AXI_WR_BURST_CHECK_EN
    logic [1:0] resp_q;
    logic       unused;

    assign last_beat   = axi_wlast_i;
    assign beat_err    = (burst_q != 2'b01)
                      || (len_q != 8'(BEATS - 1))
                      || (count_q != 9'(BEATS - 1));
    assign axi_bresp_o = resp_q;
    assign unused      = ^axi_awaddr_i[3:0];

    // SLVERR is latched on the closing beat of a malformed burst
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_q <= 2'b00;
        end else if (aw_fire) begin
            resp_q <= 2'b00;
        end else if (w_fire && last_beat && beat_err) begin
            resp_q <= 2'b10;
        end
    end
`else
    logic unused;

    assign last_beat   = (count_q == 9'(BEATS - 1));
    assign beat_err    = 1'b0;
    assign axi_bresp_o = 2'b00;
    assign unused      = ^{len_q, burst_q, axi_wlast_i, axi_awaddr_i[3:0]};
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one burst in flight, store then respond
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (aw_fire) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_fire && last_beat) begin
                    state_d = beat_err ? RESP : STORE;
                end
            end
            STORE: begin
                if (mem_accept_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi_bready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and beat packing into the 128-bit store image
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            len_q   <= '0;
            burst_q <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
        end else if (aw_fire) begin
            count_q <= '0;
            len_q   <= axi_awlen_i;
            burst_q <= axi_awburst_i;
            id_q    <= axi_awid_i;
            addr_q  <= {axi_awaddr_i[ADDRS-1:4], 4'h0};
            mask_q  <= '0;
            data_q  <= '0;
        end else if (w_fire) begin
            if (count_q != 9'd511) begin
                count_q <= count_q + 9'd1;
            end
            for (int b = 0; b < BEATS; b++) begin
                if (count_q == 9'(b)) begin
                    data_q[b*WIDTH +: WIDTH] <= axi_wdata_i;
                    mask_q[b*SW +: SW]       <= axi_wstrb_i;
                end
            end
        end
    end

endmodule
